// File: rtl/mem_pkg.sv
// Shared encodings for the memory-stage load/store unit: FSM states,
// Funct3 access sizes, ResultSrc selects and access-legality helpers.
package mem_pkg;

  typedef enum logic {
    IDLE,
    WAIT_RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  // Unsigned variants only exist for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_load);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = is_load;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_H, F3_HU: bad = lane[0];
      F3_W:        bad = (lane != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and lane replication, load lane
// extraction with sign/zero extension.
module lsu_align
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            st_funct3_i,
  input  logic [1:0]            st_lane_i,
  input  logic [DATA_WIDTH-1:0] st_data_i,
  output logic [3:0]            be_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic [2:0]            ld_funct3_i,
  input  logic [1:0]            ld_lane_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = st_data_i;
    case (st_funct3_i)
      F3_B, F3_BU: begin
        be_o    = 4'b0001 << st_lane_i;
        wdata_o = {(DATA_WIDTH/8){st_data_i[7:0]}};
      end
      F3_H, F3_HU: begin
        be_o    = 4'b0011 << st_lane_i;
        wdata_o = {(DATA_WIDTH/16){st_data_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = st_data_i;
      end
    endcase
  end

  always_comb begin
    ld_byte   = rdata_i[{ld_lane_i, 3'b000} +: 8];
    ld_half   = rdata_i[{ld_lane_i[1], 4'b0000} +: 16];
    ld_data_o = rdata_i;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      F3_H:    ld_data_o = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory pipeline stage: issues data-memory requests, stalls the pipe while
// the bus is busy, and holds the M/W pipeline register.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH             = 32,
  parameter int PC_WIDTH               = 32,
  parameter int REGISTER_ADDRESS_WIDTH = 5
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              RegWriteM_i,
  input  logic [1:0]                        ResultSrcM_i,
  input  logic                              MemWriteM_i,
  input  logic [2:0]                        Funct3M_i,
  input  logic [DATA_WIDTH-1:0]             ALUResultM_i,
  input  logic [DATA_WIDTH-1:0]             WriteDataM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
  input  logic [PC_WIDTH-1:0]               PCPlus4M_i,
  output logic                              dmem_req_o,
  output logic                              dmem_we_o,
  output logic [DATA_WIDTH-1:0]             dmem_addr_o,
  output logic [DATA_WIDTH-1:0]             dmem_wdata_o,
  output logic [3:0]                        dmem_be_o,
  input  logic                              dmem_ready_i,
  input  logic                              dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]             dmem_rdata_i,
  output logic                              StallM_o,
  output logic                              MemFaultM_o,
  output logic                              RegWriteW_o,
  output logic [1:0]                        ResultSrcW_o,
  output logic [DATA_WIDTH-1:0]             ReadDataW_o,
  output logic [DATA_WIDTH-1:0]             ALUResultW_o,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_o,
  output logic [PC_WIDTH-1:0]               PCPlus4W_o
);

  lsu_state_e            state_q, state_d;
  logic                  is_load, is_store, acc_fault, load_done;
  logic [1:0]            lane;
  logic [1:0]            ld_lane_q;
  logic [2:0]            ld_f3_q;
  logic [DATA_WIDTH-1:0] ld_data;

  assign lane      = ALUResultM_i[1:0];
  assign is_store  = MemWriteM_i;
  assign is_load   = (ResultSrcM_i == RS_MEM) && !MemWriteM_i;
  assign acc_fault = (is_load || is_store) &&
                     (!f3_legal(Funct3M_i, is_load) || misaligned(Funct3M_i, lane));

  assign dmem_addr_o = {ALUResultM_i[DATA_WIDTH-1:2], 2'b00};

  lsu_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .st_funct3_i (Funct3M_i),
    .st_lane_i   (lane),
    .st_data_i   (WriteDataM_i),
    .be_o        (dmem_be_o),
    .wdata_o     (dmem_wdata_o),
    .ld_funct3_i (ld_f3_q),
    .ld_lane_i   (ld_lane_q),
    .rdata_i     (dmem_rdata_i),
    .ld_data_o   (ld_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (is_load && !acc_fault && dmem_ready_i) state_d = WAIT_RESP;
      WAIT_RESP: if (dmem_rvalid_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    StallM_o    = 1'b0;
    MemFaultM_o = 1'b0;
    load_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc_fault) begin
          MemFaultM_o = 1'b1;
        end else if (is_store) begin
          dmem_req_o = 1'b1;
          dmem_we_o  = 1'b1;
          StallM_o   = !dmem_ready_i;
        end else if (is_load) begin
          dmem_req_o = 1'b1;
          StallM_o   = 1'b1;
        end
      end
      WAIT_RESP: begin
        StallM_o  = !dmem_rvalid_i;
        load_done = dmem_rvalid_i;
      end
      default: ;
    endcase
    // Handshake/status outputs must read low while reset is asserted,
    // even though the M inputs may still present a memory op.
    if (!rst_ni) begin
      dmem_req_o  = 1'b0;
      StallM_o    = 1'b0;
      MemFaultM_o = 1'b0;
    end
  end

  // Lane and size are kept from the accepted request so extraction does not
  // depend on the M inputs staying frozen.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ld_lane_q <= '0;
      ld_f3_q   <= '0;
    end else if (state_q == IDLE && dmem_req_o && !dmem_we_o && dmem_ready_i) begin
      ld_lane_q <= lane;
      ld_f3_q   <= Funct3M_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      RegWriteW_o  <= 1'b0;
      ResultSrcW_o <= '0;
      ReadDataW_o  <= '0;
      ALUResultW_o <= '0;
      RdW_o        <= '0;
      PCPlus4W_o   <= '0;
    end else if (StallM_o || MemFaultM_o) begin
      RegWriteW_o <= 1'b0;
    end else begin
      RegWriteW_o  <= RegWriteM_i;
      ResultSrcW_o <= ResultSrcM_i;
      ALUResultW_o <= ALUResultM_i;
      RdW_o        <= RdM_i;
      PCPlus4W_o   <= PCPlus4M_i;
      if (load_done) ReadDataW_o <= ld_data;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a transaction-level reference model
// checked every cycle plus literal expectations for key scenarios.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        ready, rvalid;
  logic [31:0] rdata;

  logic        dmem_req, dmem_we, StallM, MemFaultM, RegWriteW;
  logic [31:0] dmem_addr, dmem_wdata, ReadDataW, ALUResultW, PCPlus4W;
  logic [3:0]  dmem_be;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;

  always #5 clk = ~clk;

  mem_stage_lsu #(
    .DATA_WIDTH(32),
    .PC_WIDTH(32),
    .REGISTER_ADDRESS_WIDTH(5)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .RegWriteM_i(RegWriteM), .ResultSrcM_i(ResultSrcM), .MemWriteM_i(MemWriteM),
    .Funct3M_i(Funct3M), .ALUResultM_i(ALUResultM), .WriteDataM_i(WriteDataM),
    .RdM_i(RdM), .PCPlus4M_i(PCPlus4M),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
    .dmem_wdata_o(dmem_wdata), .dmem_be_o(dmem_be), .dmem_ready_i(ready),
    .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
    .StallM_o(StallM), .MemFaultM_o(MemFaultM),
    .RegWriteW_o(RegWriteW), .ResultSrcW_o(ResultSrcW), .ReadDataW_o(ReadDataW),
    .ALUResultW_o(ALUResultW), .RdW_o(RdW), .PCPlus4W_o(PCPlus4W)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_wait;
  logic [1:0]  m_lane;
  logic [2:0]  m_f3;
  logic        e_rw;
  logic [1:0]  e_rs;
  logic [31:0] e_rdata, e_alu, e_pc;
  logic [4:0]  e_rd;
  logic        x_req, x_we, x_stall, x_fault;
  logic [31:0] x_addr, x_wdata;
  logic [3:0]  x_be;

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] rd);
    int     n;
    longint v, span;
    n = size_of(f3);
    if (n == 4) return rd;
    span = longint'(1) << (8 * n);
    v = longint'(rd >> (8 * lane)) % span;
    if (!f3[2] && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function void eval_bus();
    bit ld, st, legal;
    int n, a;
    ld = (ResultSrcM == 2'b01) && !MemWriteM;
    st = MemWriteM;
    n  = size_of(Funct3M);
    a  = int'(ALUResultM % 4);
    legal = st ? (Funct3M <= 3'd2)
               : (Funct3M <= 3'd2 || Funct3M == 3'd4 || Funct3M == 3'd5);
    if (legal && (int'(ALUResultM % 4) % n) != 0) legal = 0;
    x_req = 0; x_we = 0; x_stall = 0; x_fault = 0;
    x_addr = ALUResultM - (ALUResultM % 4);
    x_be   = 4'(((1 << n) - 1) << a);
    if (n == 1)      x_wdata = (WriteDataM & 32'hFF) * 32'h01010101;
    else if (n == 2) x_wdata = (WriteDataM & 32'hFFFF) * 32'h00010001;
    else             x_wdata = WriteDataM;
    if (!rst_n) return;
    if (m_wait) x_stall = !rvalid;
    else if ((ld || st) && !legal) x_fault = 1;
    else if (st) begin x_req = 1; x_we = 1; x_stall = !ready; end
    else if (ld) begin x_req = 1; x_stall = 1; end
  endfunction

  function void capture_w();
    e_rw = RegWriteM; e_rs = ResultSrcM; e_alu = ALUResultM; e_rd = RdM; e_pc = PCPlus4M;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait = 0; m_lane = 0; m_f3 = 0;
      e_rw = 0; e_rs = 0; e_rdata = 0; e_alu = 0; e_rd = 0; e_pc = 0;
    end else begin
      eval_bus();
      if (m_wait) begin
        if (rvalid) begin
          capture_w();
          e_rdata = model_load(m_f3, m_lane, rdata);
          m_wait  = 0;
        end else e_rw = 0;
      end else if (x_fault || x_stall) begin
        e_rw = 0;
        if (x_req && !x_we && ready) begin
          m_wait = 1; m_lane = ALUResultM[1:0]; m_f3 = Funct3M;
        end
      end else capture_w();
    end
  end

  always @(negedge clk) begin
    eval_bus();
    chk("req", 32'(dmem_req), 32'(x_req));
    chk("stall", 32'(StallM), 32'(x_stall));
    chk("fault", 32'(MemFaultM), 32'(x_fault));
    if (x_req) begin
      chk("we", 32'(dmem_we), 32'(x_we));
      chk("addr", dmem_addr, x_addr);
      if (x_we) begin
        chk("be", 32'(dmem_be), 32'(x_be));
        chk("wdata", dmem_wdata, x_wdata);
      end
    end
    chk("RegWriteW", 32'(RegWriteW), 32'(e_rw));
    chk("ResultSrcW", 32'(ResultSrcW), 32'(e_rs));
    chk("ReadDataW", ReadDataW, e_rdata);
    chk("ALUResultW", ALUResultW, e_alu);
    chk("RdW", 32'(RdW), 32'(e_rd));
    chk("PCPlus4W", PCPlus4W, e_pc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    RegWriteM = 0; ResultSrcM = 0; MemWriteM = 0; Funct3M = 0;
    ALUResultM = 0; WriteDataM = 0; RdM = 0; PCPlus4M = 0;
    rvalid = 0; ready = 1; rdata = 0;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input int waits);
    MemWriteM = 1; RegWriteM = 0; Funct3M = f3; ALUResultM = addr; WriteDataM = data;
    PCPlus4M = addr + 4;
    ready = (waits == 0);
    for (int i = 0; i < waits; i++) begin
      tick();
      if (i == waits - 1) ready = 1;
    end
    tick();
    nop();
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                         input logic [31:0] data, input int lat);
    RegWriteM = 1; ResultSrcM = 2'b01; MemWriteM = 0; Funct3M = f3; ALUResultM = addr;
    RdM = rd; PCPlus4M = addr + 32'h1000;
    tick();
    for (int i = 1; i < lat; i++) tick();
    rvalid = 1; rdata = data;
    tick();
    nop();
  endtask

  initial begin
    nop();
    rst_n = 0;
    MemWriteM = 1;
    @(negedge clk);
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_stall", 32'(StallM), 0);
    chk("rst_rw", 32'(RegWriteW), 0);
    chk("rst_rdata", ReadDataW, 0);
    tick();
    rst_n = 1;
    nop();
    tick();

    // ADD: result 0x10 to x5
    RegWriteM = 1; ResultSrcM = 2'b00; ALUResultM = 32'h10; RdM = 5; PCPlus4M = 32'h104;
    @(negedge clk);
    chk("add_stall", 32'(StallM), 0);
    tick();
    nop();
    @(negedge clk);
    chk("add_rw", 32'(RegWriteW), 1);
    chk("add_alu", ALUResultW, 32'h10);
    chk("add_rd", 32'(RdW), 5);
    tick();

    // SB 0xAB at 0x103 with ready low for two cycles
    MemWriteM = 1; Funct3M = 3'b000; ALUResultM = 32'h103; WriteDataM = 32'hAB; ready = 0;
    @(negedge clk);
    chk("sb_stall_c1", 32'(StallM), 1);
    chk("sb_be", 32'(dmem_be), 32'b1000);
    chk("sb_wdata", dmem_wdata, 32'hABABABAB);
    chk("sb_addr", dmem_addr, 32'h100);
    tick();
    @(negedge clk);
    chk("sb_stall_c2", 32'(StallM), 1);
    tick();
    ready = 1;
    @(negedge clk);
    chk("sb_stall_c3", 32'(StallM), 0);
    tick();
    nop();

    // LB / LBU at 0x202, response three cycles after accept
    do_load(3'b000, 32'h202, 5'd7, 32'h00800000, 3);
    @(negedge clk);
    chk("lb_data", ReadDataW, 32'hFFFFFF80);
    chk("lb_rw", 32'(RegWriteW), 1);
    chk("lb_rd", 32'(RdW), 7);
    tick();
    do_load(3'b100, 32'h202, 5'd8, 32'h00800000, 3);
    @(negedge clk);
    chk("lbu_data", ReadDataW, 32'h00000080);
    tick();

    // Further stores and loads checked against the model
    do_store(3'b001, 32'h102, 32'h00001234, 0);
    do_store(3'b010, 32'h20C, 32'hCAFEBABE, 1);
    do_store(3'b000, 32'h0F0, 32'h12345678, 0);
    do_load(3'b001, 32'h106, 5'd10, 32'h80010000, 1);
    @(negedge clk);
    chk("lh_data", ReadDataW, 32'hFFFF8001);
    tick();
    do_load(3'b101, 32'h106, 5'd11, 32'h80010000, 2);
    @(negedge clk);
    chk("lhu_data", ReadDataW, 32'h00008001);
    tick();
    do_load(3'b010, 32'h208, 5'd12, 32'h12345678, 2);
    do_load(3'b000, 32'h001, 5'd13, 32'h00007F00, 1);

    // Illegal and misaligned accesses
    do_store(3'b100, 32'h100, 32'h1, 0);
    do_store(3'b001, 32'h101, 32'h1, 0);
    do_load(3'b110, 32'h100, 5'd14, 32'h5555AAAA, 1);

    // LW at 0x206: fault
    RegWriteM = 1; ResultSrcM = 2'b01; Funct3M = 3'b010; ALUResultM = 32'h206; RdM = 3;
    @(negedge clk);
    chk("lw_mis_fault", 32'(MemFaultM), 1);
    chk("lw_mis_req", 32'(dmem_req), 0);
    chk("lw_mis_stall", 32'(StallM), 0);
    tick();
    nop();
    @(negedge clk);
    chk("lw_mis_fault_gone", 32'(MemFaultM), 0);
    chk("lw_mis_rw", 32'(RegWriteW), 0);
    tick();

    // Reset while waiting for a load response, then a stale response
    RegWriteM = 1; ResultSrcM = 2'b01; Funct3M = 3'b010; ALUResultM = 32'h300; RdM = 9;
    PCPlus4M = 32'h500;
    tick();
    tick();
    #1 rst_n = 0;
    @(negedge clk);
    chk("mid_rst_rw", 32'(RegWriteW), 0);
    chk("mid_rst_rdata", ReadDataW, 0);
    chk("mid_rst_alu", ALUResultW, 0);
    chk("mid_rst_pc", PCPlus4W, 0);
    chk("mid_rst_rd", 32'(RdW), 0);
    chk("mid_rst_stall", 32'(StallM), 0);
    tick();
    rst_n = 1;
    nop();
    rvalid = 1; rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("stale_stall", 32'(StallM), 0);
    tick();
    rvalid = 0;
    @(negedge clk);
    chk("stale_rw", 32'(RegWriteW), 0);
    chk("stale_rdata", ReadDataW, 0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data/address width.
REQ-002 SHALL have parameter PC_WIDTH, default 32, PC width.
REQ-003 SHALL have parameter REGISTER_ADDRESS_WIDTH, default 5, rd width.
REQ-004 SHALL have port clk_i, in, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni, in, 1, asynchronous active-low reset.
REQ-006 SHALL have ports RegWriteM_i in 1, ResultSrcM_i in 2, MemWriteM_i in 1, Funct3M_i in 3, ALUResultM_i in DATA_WIDTH, WriteDataM_i in DATA_WIDTH, RdM_i in REGISTER_ADDRESS_WIDTH, PCPlus4M_i in PC_WIDTH; Memory-stage controls and operands.
REQ-007 SHALL have ports dmem_req_o out 1, dmem_we_o out 1, dmem_addr_o out DATA_WIDTH (word-aligned), dmem_wdata_o out DATA_WIDTH, dmem_be_o out 4, dmem_ready_i in 1, dmem_rvalid_i in 1, dmem_rdata_i in DATA_WIDTH; data-memory bus.
REQ-008 SHALL have ports StallM_o out 1 (freeze F/D/E/M registers) and MemFaultM_o out 1 (misaligned/illegal access pulse).
REQ-009 SHALL have ports RegWriteW_o out 1, ResultSrcW_o out 2, ReadDataW_o out DATA_WIDTH, ALUResultW_o out DATA_WIDTH, RdW_o out REGISTER_ADDRESS_WIDTH, PCPlus4W_o out PC_WIDTH; Writeback-stage register outputs.

Function
REQ-010 SHALL classify: load = ResultSrcM_i==2'b01 and MemWriteM_i==0; store = MemWriteM_i==1; otherwise non-memory.
REQ-011 SHALL accept Funct3M_i 000/001/010 (B/H/W) and, for loads only, 100/101 (BU/HU); any other value on a memory op is a fault.
REQ-012 SHALL fault on H access with addr[0]=1 or W access with addr[1:0]!=0.
REQ-013 SHALL, on fault: no request, MemFaultM_o=1 that cycle only, no stall, W register loads a bubble (RegWriteW_o=0) next edge.
REQ-014 SHALL implement FSM IDLE, WAIT_RESP; bus handshake completes on a cycle with dmem_req_o && dmem_ready_i.
REQ-015 SHALL, in IDLE with a non-memory op: StallM_o=0, dmem_req_o=0, W register captures M inputs next edge (1-cycle latency).
REQ-016 SHALL, in IDLE with a valid store: dmem_req_o=1, dmem_we_o=1, StallM_o=!dmem_ready_i; on handshake W register captures, state stays IDLE.
REQ-017 SHALL, in IDLE with a valid load: dmem_req_o=1, dmem_we_o=0, StallM_o=1; on handshake go to WAIT_RESP.
REQ-018 SHALL, in WAIT_RESP: dmem_req_o=0, StallM_o=!dmem_rvalid_i; on dmem_rvalid_i capture aligned/extended data into ReadDataW_o, capture remaining M fields, return to IDLE.
REQ-019 SHALL ignore dmem_rvalid_i in IDLE.
REQ-020 SHALL load a bubble (RegWriteW_o=0, other W fields don't-care but deterministic: hold) on every edge where StallM_o=1.
REQ-021 SHALL drive dmem_addr_o = {ALUResultM_i[31:2],2'b00}; byte enables SB 0001<<a[1:0], SH 0011<<a[1:0], SW 1111; dmem_wdata_o = byte/half replicated across lanes.
REQ-022 SHALL extract load lane by a[1:0] (held from request), sign-extend LB/LH, zero-extend LBU/LHU, pass LW.
REQ-023 SHALL hold request outputs stable while dmem_req_o=1 and dmem_ready_i=0.

Reset
REQ-024 SHALL, on rst_ni=0 (asynchronous), force state IDLE and all W outputs to 0; dmem_req_o, StallM_o, MemFaultM_o read 0 during reset.
REQ-025 SHALL abandon an outstanding load on reset mid-WAIT_RESP; the late response is ignored per REQ-019.

Structure
REQ-026 SHALL place state enum, Funct3 load/store encodings and ResultSrc encodings in shared package mem_pkg.
REQ-027 SHALL use one combinational sub-module lsu_align for byte-enable, write replication and load extraction.

Verification
REQ-028 SHALL cover ADD result 0x0000_0010, rd=5: W outputs on next edge, RegWriteW_o=1, StallM_o never 1.
REQ-029 SHALL cover SB addr 0x103, data 0xAB, ready low 2 cycles: StallM_o=1 for 2 cycles, dmem_be_o=1000, dmem_wdata_o=0xABABABAB, addr 0x100.
REQ-030 SHALL cover LB addr 0x202, rdata 0x00800000, rvalid 3 cycles after accept: ReadDataW_o=0xFFFFFF80, LBU variant gives 0x00000080.
REQ-031 SHALL cover LW addr 0x206: MemFaultM_o=1 one cycle, dmem_req_o=0, RegWriteW_o=0.
REQ-032 SHALL cover rst_ni low in WAIT_RESP then rvalid after release: state IDLE, all W outputs 0, response ignored.
